mb_scan_ctrl: RTL and testbench
===============================

// Module: mb_scan_ctrl
// PURPOSE
//  Scan sequencer for the encoder's data-handling front end. Walks a frame in
//  16x16 macroblock (MB) raster order and, within each MB, issues the sixteen
//  4x4 block pixel coordinates to the fetch/transform datapath.
//  Issues coordinates over a valid/ready handshake.
//  After each MB it holds until the pipeline acknowledges that MB.
// PARAMETERS
//  FRAME_W  640  luma frame width in pixels; multiple of 16, >=16
//  FRAME_H  480  luma frame height in pixels; multiple of 16, >=16
//  COORD_W  16   width of all coordinate outputs; must hold FRAME_W-1, FRAME_H-1
// PORTS
//  clk         in   1        clock; all state changes on posedge
//  rst         in   1        reset, synchronous, active-high
//  start       in   1        one-cycle pulse: begin a frame scan (used only in IDLE)
//  blk_valid   out  1        blk_x/blk_y hold a valid 4x4 block origin
//  blk_ready   in   1        downstream accepts; transfer = blk_valid & blk_ready
//  blk_x       out  COORD_W  pixel x of current 4x4 block origin
//  blk_y       out  COORD_W  pixel y of current 4x4 block origin
//  blk_idx     out  4        index 0..15 of block within its MB, in emission order
//  mb_x        out  COORD_W  pixel x of current MB origin (multiple of 16)
//  mb_y        out  COORD_W  pixel y of current MB origin (multiple of 16)
//  mb_last_blk out  1        current block is the 16th of its MB
//  mb_ack      in   1        pipeline done with current MB (used only in WAIT_ACK)
//  busy        out  1        state != IDLE
//  frame_done  out  1        one-cycle pulse: last MB of frame acknowledged
// BEHAVIOUR
//  - Reset: state=IDLE; mb_x=mb_y=0; blk_idx=0; blk_valid=0; busy=0; frame_done=0.
//  - All outputs derive from registers only; no combinational input->output path.
//  - States:
//      IDLE     : start -> SCAN next cycle, counters cleared to 0.
//      SCAN     : blk_valid=1. On a transfer:
//                   blk_idx != 15 : blk_idx++
//                   blk_idx == 15 : -> WAIT_ACK
//      WAIT_ACK : blk_valid=0. On mb_ack:
//                   not last MB : -> SCAN. mb_x += 16; at FRAME_W wrap mb_x=0, mb_y += 16.
//                                 blk_idx=0.
//                   last MB     : -> IDLE, frame_done=1 for that one cycle, counters cleared.
//  - First blk_valid appears 1 cycle after start is sampled.
//  - Max throughput is 1 block/cycle while blk_ready=1.
//  - Handshake: blk_valid must not drop and outputs must not change until the transfer.
//    blk_valid never depends on blk_ready.
//  - blk_x = mb_x + 4*col, blk_y = mb_y + 4*row. (row,col) comes from blk_idx via the
//    order table. All arithmetic is unsigned COORD_W; the MB step never exceeds the frame.
//  - Last MB: mb_x == FRAME_W-16 and mb_y == FRAME_H-16. mb_last_blk = (blk_idx == 15).
//  - Ignored inputs: start while busy; mb_ack outside WAIT_ACK (including the cycle of
//    entry into WAIT_ACK, since ack is sampled only while in that state); blk_ready in
//    IDLE/WAIT_ACK.
//  - rst mid-scan: returns to IDLE with reset values next cycle; frame_done is NOT pulsed.
//  - Degenerate 16x16 frame: a single MB, then frame_done.
// CONFIGURATION
//  H264_BLK_ORDER_EN defined: emission follows H.264 luma4x4BlkIdx order, i.e. 8x8
//    quadrants TL,TR,BL,BR, each quadrant's 4x4 blocks TL,TR,BL,BR.
//    (row,col) for idx 0..3 = (0,0),(0,1),(1,0),(1,1); idx 4 = (0,2).
//  H264_BLK_ORDER_EN undefined: raster within MB, row = idx[3:2], col = idx[1:0]
//    (x steps +4, wraps by -12 with y += 4).
//  Handshake, timing and MB order are identical in both builds.
// STRUCTURE
//  - Package h264_scan_pkg: MB_SIZE=16, BLK_SIZE=4, BLKS_PER_MB=16.
//    Also holds typedef enum logic [1:0] {IDLE, SCAN, WAIT_ACK} scan_state_t.
//    Also holds the function blk_idx_to_rowcol() holding both order tables.
//  - One sub-module, mb_pos_counter: mb_x/mb_y registers with advance/clear and a
//    last_mb flag.
//  - FSM, blk_idx counter and coordinate adders stay in mb_scan_ctrl.
// TESTING  (FRAME_W=32, FRAME_H=32 -> 4 MBs, 64 blocks)
//  1. rst=1 for 2 cycles -> all outputs at reset values. start, blk_ready=1 ->
//     blk_valid next cycle, blk_x=0 blk_y=0 blk_idx=0.
//  2. Raster build, ready=1: blocks 0..3 give blk_x=0,4,8,12 with blk_y=0; block 4 gives
//     (0,4); block 15 gives (12,12) with mb_last_blk=1. Then blk_valid=0 in WAIT_ACK.
//  3. Hold mb_ack=0 for 5 cycles -> no change. Pulse mb_ack -> next block (16,0).
//     After the 2nd ack -> MB (0,16). After the 4th ack -> frame_done=1 for 1 cycle,
//     busy=0.
//  4. Toggle blk_ready randomly (~50%) -> 64 transfers. Outputs stable while
//     valid&!ready. Order is identical to test 2.
//  5. start pulsed mid-scan -> no effect. rst asserted at block 20 -> IDLE next cycle,
//     no frame_done. A new start resumes at (0,0).
//  6. H264_BLK_ORDER_EN build: MB0 blocks 0..5 -> (0,0),(4,0),(0,4),(4,4),(8,0),(12,0).
//     Block 15 -> (12,12).

Source files
------------

// File: rtl/h264_scan_pkg.sv
// Shared constants, FSM state type and 4x4 block ordering for the MB scan sequencer.
package h264_scan_pkg;

    localparam int MB_SIZE     = 16;
    localparam int BLK_SIZE    = 4;
    localparam int BLKS_PER_MB = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WAIT_ACK
    } scan_state_t;

    // Returns {row[1:0], col[1:0]} of a 4x4 block inside its MB for emission index idx.
    // H.264 order interleaves the index bits: row = {idx[3], idx[1]}, col = {idx[2], idx[0]}.
    function automatic logic [3:0] blk_idx_to_rowcol(input logic [3:0] idx,
                                                     input logic       h264_order);
        logic [3:0] rc;
        if (h264_order) begin
            rc = {idx[3], idx[1], idx[2], idx[0]};
        end else begin
            rc = idx;
        end
        return rc;
    endfunction

endpackage

// File: rtl/mb_pos_counter.sv
// Macroblock origin counter: walks mb_x/mb_y in raster order in steps of one MB.
module mb_pos_counter
    import h264_scan_pkg::*;
#(
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int COORD_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] mb_x,
    output logic [COORD_W-1:0] mb_y,
    output logic               last_mb
);

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(FRAME_W - MB_SIZE);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(FRAME_H - MB_SIZE);
    localparam logic [COORD_W-1:0] MB_STEP = COORD_W'(MB_SIZE);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            mb_x <= '0;
            mb_y <= '0;
        end else if (advance) begin
            if (mb_x == X_LAST) begin
                mb_x <= '0;
                mb_y <= mb_y + MB_STEP;
            end else begin
                mb_x <= mb_x + MB_STEP;
            end
        end
    end

    assign last_mb = (mb_x == X_LAST) && (mb_y == Y_LAST);

endmodule

// File: rtl/mb_scan_ctrl.sv
// Frame scan sequencer: issues 4x4 block origins per MB over valid/ready, then waits for MB ack.
// Define H264_BLK_ORDER_EN for H.264 luma4x4BlkIdx emission order; default is raster within MB.
module mb_scan_ctrl
    import h264_scan_pkg::*;
#(
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int COORD_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [COORD_W-1:0] blk_x,
    output logic [COORD_W-1:0] blk_y,
    output logic [3:0]         blk_idx,
    output logic [COORD_W-1:0] mb_x,
    output logic [COORD_W-1:0] mb_y,
    output logic               mb_last_blk,
    input  logic               mb_ack,
    output logic               busy,
    output logic               frame_done
);

`ifdef H264_BLK_ORDER_EN
    localparam logic H264_ORDER = 1'b1;
`else
    localparam logic H264_ORDER = 1'b0;
`endif

    localparam logic [3:0] LAST_IDX = 4'(BLKS_PER_MB - 1);

    scan_state_t state, state_nxt;
    logic [3:0]  blk_idx_nxt;
    logic        pos_clear, pos_adv, done_nxt, last_mb;
    logic [3:0]  rc;

    mb_pos_counter #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H),
        .COORD_W (COORD_W)
    ) u_pos (
        .clk     (clk),
        .rst     (rst),
        .clear   (pos_clear),
        .advance (pos_adv),
        .mb_x    (mb_x),
        .mb_y    (mb_y),
        .last_mb (last_mb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            blk_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            blk_idx    <= blk_idx_nxt;
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        blk_idx_nxt = blk_idx;
        pos_clear   = 1'b0;
        pos_adv     = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = SCAN;
                    blk_idx_nxt = '0;
                    pos_clear   = 1'b1;
                end
            end
            SCAN: begin
                if (blk_ready) begin
                    if (blk_idx == LAST_IDX) begin
                        state_nxt = WAIT_ACK;
                    end else begin
                        blk_idx_nxt = blk_idx + 4'd1;
                    end
                end
            end
            WAIT_ACK: begin
                if (mb_ack) begin
                    blk_idx_nxt = '0;
                    if (last_mb) begin
                        state_nxt = IDLE;
                        pos_clear = 1'b1;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = SCAN;
                        pos_adv   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Everything below depends only on registered state, so there is no input->output path.
    assign blk_valid   = (state == SCAN);
    assign busy        = (state != IDLE);
    assign mb_last_blk = (blk_idx == LAST_IDX);
    assign rc          = blk_idx_to_rowcol(blk_idx, H264_ORDER);
    assign blk_x       = mb_x + COORD_W'(rc[1:0]) * COORD_W'(BLK_SIZE);
    assign blk_y       = mb_y + COORD_W'(rc[3:2]) * COORD_W'(BLK_SIZE);

endmodule

// File: tb/tb_mb_scan_ctrl.sv
// Directed bench for mb_scan_ctrl on a 32x32 frame (4 MBs, 64 blocks); honours H264_BLK_ORDER_EN.
module tb_mb_scan_ctrl;

    localparam int FW = 32;
    localparam int FH = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          blk_ready = 1'b0;
    logic          mb_ack = 1'b0;
    logic          blk_valid, mb_last_blk, busy, frame_done;
    logic [CW-1:0] blk_x, blk_y, mb_x, mb_y;
    logic [3:0]    blk_idx;

    int n_cmp = 0;
    int n_err = 0;

    // H.264 luma4x4BlkIdx pixel offsets inside an MB, written out by hand.
    int h_xo [16] = '{0, 4, 0, 4, 8, 12, 8, 12, 0, 4, 0, 4, 8, 12, 8, 12};
    int h_yo [16] = '{0, 0, 4, 4, 0, 0, 4, 4, 8, 8, 12, 12, 8, 8, 12, 12};

    mb_scan_ctrl #(.FRAME_W(FW), .FRAME_H(FH), .COORD_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .blk_valid   (blk_valid),
        .blk_ready   (blk_ready),
        .blk_x       (blk_x),
        .blk_y       (blk_y),
        .blk_idx     (blk_idx),
        .mb_x        (mb_x),
        .mb_y        (mb_y),
        .mb_last_blk (mb_last_blk),
        .mb_ack      (mb_ack),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_blk(input int mb, input int k);
        int ox, oy, mx, my;
        mx = (mb % 2) * 16;
        my = (mb / 2) * 16;
`ifdef H264_BLK_ORDER_EN
        ox = h_xo[k];
        oy = h_yo[k];
`else
        ox = (k % 4) * 4;
        oy = (k / 4) * 4;
`endif
        check("blk_valid", 32'(blk_valid), 1);
        check("blk_x", 32'(blk_x), 32'(mx + ox));
        check("blk_y", 32'(blk_y), 32'(my + oy));
        check("blk_idx", 32'(blk_idx), 32'(k));
        check("mb_x", 32'(mb_x), 32'(mx));
        check("mb_y", 32'(mb_y), 32'(my));
        check("mb_last_blk", 32'(mb_last_blk), (k == 15) ? 1 : 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Runs one whole frame; rnd toggles blk_ready ~50% per cycle.
    task automatic run_frame(input bit rnd);
        bit r;
        int guard;
        for (int mb = 0; mb < 4; mb++) begin
            for (int k = 0; k < 16; k++) begin
                guard = 0;
                do begin
                    r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    blk_ready = r;
                    // ack arriving while still in SCAN must be ignored
                    mb_ack = (mb == 1 && k == 15);
                    check_blk(mb, k);
                    step();
                    guard++;
                end while (!r && guard < 100);
                if (!r) check("ready_timeout", 0, 1);
            end
            mb_ack = 1'b0;
            blk_ready = 1'b1;
            check("wait_valid", 32'(blk_valid), 0);
            check("wait_busy", 32'(busy), 1);
            if (mb == 0) begin
                for (int h = 0; h < 5; h++) begin
                    step();
                    check("hold_valid", 32'(blk_valid), 0);
                    check("hold_idx", 32'(blk_idx), 15);
                    check("hold_mb_x", 32'(mb_x), 0);
                end
            end
            if (mb == 1) begin
                step();
                check("entry_ack_ignored", 32'(blk_valid), 0);
            end
            mb_ack = 1'b1;
            step();
            mb_ack = 1'b0;
            if (mb == 3) begin
                check("frame_done", 32'(frame_done), 1);
                check("done_busy", 32'(busy), 0);
                check("done_valid", 32'(blk_valid), 0);
                check("done_mb_x", 32'(mb_x), 0);
                step();
                check("frame_done_pulse", 32'(frame_done), 0);
            end
        end
    endtask

    initial begin
        // reset
        step();
        step();
        rst = 1'b0;
        check("rst_valid", 32'(blk_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_mb_x", 32'(mb_x), 0);
        check("rst_mb_y", 32'(mb_y), 0);
        check("rst_idx", 32'(blk_idx), 0);

        // full-ready frame
        blk_ready = 1'b1;
        pulse_start();
        run_frame(1'b0);

        // random-ready frame
        pulse_start();
        run_frame(1'b1);

        // start mid-scan, then reset at block 20
        blk_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            start = (k == 3);
            check_blk(0, k);
            step();
        end
        start = 1'b0;
        mb_ack = 1'b1;
        step();
        mb_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_blk(1, k);
            step();
        end
        check_blk(1, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid", 32'(blk_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(frame_done), 0);
        check("midrst_mb_x", 32'(mb_x), 0);
        check("midrst_idx", 32'(blk_idx), 0);
        step();
        check("midrst_done2", 32'(frame_done), 0);
        pulse_start();
        check_blk(0, 0);
        step();
        check_blk(0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
